// File: rtl/demux_1x2_3bit_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready on every port.
// Each output owns a one-entry holding slot and a delivered-word counter.

module demux_slot #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             room
);

  logic deliver;

  assign deliver = f_valid & ready;
  // Slot can take a word if empty or being drained this same cycle.
  assign room    = ~f_valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f       <= '0;
      f_valid <= 1'b0;
    end else if (load) begin
      f       <= data;
      f_valid <= 1'b1;
    end else if (deliver) begin
      f_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (deliver) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module demux_1x2_3bit_reg #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             s,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [WIDTH-1:0] f0,
  output logic             f0_valid,
  input  logic             f0_ready,
  output logic [WIDTH-1:0] f1,
  output logic             f1_valid,
  input  logic             f1_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic room0, room1;
  logic load0, load1;

  assign x_ready = s ? room1 : room0;
  assign load0   = x_valid & x_ready & ~s;
  assign load1   = x_valid & x_ready & s;

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .load    (load0),
    .data    (x),
    .ready   (f0_ready),
    .clr_cnt (clr_cnt),
    .f       (f0),
    .f_valid (f0_valid),
    .cnt     (cnt0),
    .room    (room0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .load    (load1),
    .data    (x),
    .ready   (f1_ready),
    .clr_cnt (clr_cnt),
    .f       (f1),
    .f_valid (f1_valid),
    .cnt     (cnt1),
    .room    (room1)
  );

endmodule

// File: tb/tb_demux_1x2_3bit_reg.sv
// Bench for demux_1x2_3bit_reg: directed scenarios plus random traffic,
// checked against per-output word queues and modulo delivery counts.

module tb_demux_1x2_3bit_reg;
  localparam int WIDTH = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x;
  logic             s;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] f0, f1;
  logic             f0_valid, f1_valid;
  logic             f0_ready, f1_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0, last1;
  int               mcnt0, mcnt1;

  demux_1x2_3bit_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .s        (s),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .f0       (f0),
    .f0_valid (f0_valid),
    .f0_ready (f0_ready),
    .f1       (f1),
    .f1_valid (f1_valid),
    .f1_ready (f1_ready),
    .clr_cnt  (clr_cnt),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: checks the state presented this cycle, then applies the
  // deliveries and accepts that the coming rising edge will perform.
  always @(negedge clk) begin
    logic exp_ready;
    if (rst) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      mcnt0 = 0;
      mcnt1 = 0;
      chk("rst_f0_valid", int'(f0_valid), 0);
      chk("rst_f1_valid", int'(f1_valid), 0);
      chk("rst_f0", int'(f0), 0);
      chk("rst_f1", int'(f1), 0);
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_cnt1", int'(cnt1), 0);
    end else begin
      chk("f0_valid", int'(f0_valid), int'(q0.size() != 0));
      chk("f1_valid", int'(f1_valid), int'(q1.size() != 0));
      chk("f0", int'(f0), (q0.size() != 0) ? int'(q0[0]) : int'(last0));
      chk("f1", int'(f1), (q1.size() != 0) ? int'(q1[0]) : int'(last1));
      chk("cnt0", int'(cnt0), mcnt0);
      chk("cnt1", int'(cnt1), mcnt1);
      exp_ready = s ? (q1.size() == 0 || f1_ready) : (q0.size() == 0 || f0_ready);
      chk("x_ready", int'(x_ready), int'(exp_ready));

      if (q0.size() != 0 && f0_ready) begin
        last0 = q0.pop_front();
        mcnt0 = (mcnt0 + 1) % (1 << CNT_W);
      end
      if (q1.size() != 0 && f1_ready) begin
        last1 = q1.pop_front();
        mcnt1 = (mcnt1 + 1) % (1 << CNT_W);
      end
      if (clr_cnt) begin
        mcnt0 = 0;
        mcnt1 = 0;
      end
      if (x_valid && exp_ready) begin
        if (s) q1.push_back(x);
        else   q0.push_back(x);
      end
    end
  end

  task automatic step(input logic xv, input logic [WIDTH-1:0] xd, input logic sel,
                      input logic r0, input logic r1, input logic clr);
    x_valid  = xv;
    x        = xd;
    s        = sel;
    f0_ready = r0;
    f1_ready = r1;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; x = '0; s = 1'b0; x_valid = 1'b1;
    f0_ready = 1'b0; f1_ready = 1'b0; clr_cnt = 1'b0;

    // Reset held with x_valid high
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(x_ready), 1);

    // Route 101 to output 0, then deliver
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("route_f0", int'(f0), 5);
    chk("route_f1_valid", int'(f1_valid), 0);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("route_cnt0", int'(cnt0), 1);

    // Backpressure on output 1
    step(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
    x_valid = 1'b1; x = 3'b110; s = 1'b1; f1_ready = 1'b0;
    #1;
    chk("bp_x_ready", int'(x_ready), 0);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_f1", int'(f1), 3);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("bp_reload_f1", int'(f1), 6);
    chk("bp_reload_valid", int'(f1_valid), 1);

    // Independence: f1 full and stalled, route to f0
    x_valid = 1'b1; x = 3'b111; s = 1'b0; f1_ready = 1'b0; f0_ready = 1'b0;
    #1;
    chk("ind_x_ready", int'(x_ready), 1);
    step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ind_f0", int'(f0), 7);
    chk("ind_f1", int'(f1), 6);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Streaming on output 0 with counter wrap, then clear during delivery
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_valid", int'(f0_valid), 1);
    step(1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_cnt0", int'(cnt0), 0);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with both slots valid
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    x_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_f0_valid", int'(f0_valid), 0);
    chk("async_f1_valid", int'(f1_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0));
    end

    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
